mmio_host_bridge: RTL
=====================

Name: mmio_host_bridge

Overview:
- Initiator side of the mmio_if register protocol.
- Accepts platform MMIO requests (write/read, 4- or 8-byte, with transaction ID) from the HAL shim and drives mmio_if wr_en/rd_en strobes toward user memory maps.
- Captures user read data after a fixed latency and returns tagged, in-order read responses through a buffered valid/ready port.
- Enforces the 8-byte even-address rule and counts violations.

Parameters:
- ADDR_WIDTH, 16, MMIO address width in 4-byte units.
- TID_WIDTH, 9, transaction ID width.
- RD_LATENCY, 0, cycles from mmio_rd_en to valid mmio_rd_data (0..4).
- RSP_DEPTH, 8, response FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request may be accepted this cycle
- req_write  in  1  1=write, 0=read
- req_len8  in  1  1=8-byte access, 0=4-byte
- req_addr  in  ADDR_WIDTH  request address
- req_data  in  64  write data
- req_tid  in  TID_WIDTH  read transaction ID
- mmio_wr_en  out  1  write strobe to user
- mmio_wr_addr  out  ADDR_WIDTH  write address
- mmio_wr_data  out  64  write data
- mmio_rd_en  out  1  read strobe to user
- mmio_rd_addr  out  ADDR_WIDTH  read address
- mmio_rd_data  in  64  user read data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_data  out  64  response data
- rsp_tid  out  TID_WIDTH  response transaction ID
- err_count  out  16  misaligned-access count, saturating

Behaviour:
- Reset (asynchronous, active-high): all registered outputs 0, FIFO empty, inflight=0, err_count=0. req_ready=1 during and after reset.
- Reset mid-operation: pending strobes, in-flight reads and buffered responses are discarded; no response is ever issued for them.
- Accept: a request is accepted in cycle T when req_valid && req_ready. req_ready = (fifo_count + inflight) < RSP_DEPTH. The condition applies to reads and writes alike.
- Misaligned: req_len8=1 with req_addr[0]=1.
- Write, aligned:
  - mmio_wr_en=1 for exactly cycle T+1, with mmio_wr_addr=req_addr.
  - mmio_wr_data = req_data for 8-byte writes; {32'h0, req_data[31:0]} for 4-byte writes.
- Write, misaligned: no strobe; err_count increments.
- Read, aligned:
  - mmio_rd_en=1 for exactly cycle T+1, with mmio_rd_addr=req_addr.
  - {tid, len8, misaligned flag} travels down a RD_LATENCY-stage shift register.
  - mmio_rd_data is sampled in cycle T+1+RD_LATENCY.
  - Captured data: full 64 bits for 8-byte reads; {32'h0, rd_data[31:0]} for 4-byte reads.
  - The entry is pushed into the FIFO in that cycle; rsp_valid rises at T+2+RD_LATENCY.
- Read, misaligned: no rd_en; err_count increments. The request travels the same pipeline and its response carries data 64'hFFFF_FFFF_FFFF_FFFF and its tid, so response order always equals request order.
- inflight: increments on read accept, decrements on FIFO push; both in the same cycle leaves it unchanged.
- FIFO:
  - First-word fall-through: rsp_valid = !empty, with rsp_data/rsp_tid taken from the head.
  - Pop on rsp_valid && rsp_ready.
  - Push and pop in the same cycle are both honoured, including when full or empty.
  - Outputs hold stable while rsp_valid && !rsp_ready.
  - Pointers wrap modulo RSP_DEPTH. Overflow is impossible by construction of req_ready; the bench asserts it.
- Back-to-back: one request per cycle is sustained while req_ready=1. Consecutive strobes on successive cycles are legal.
- err_count: saturates at 16'hFFFF.

Test Plan:
- Aligned 8-byte write addr 16'h0050, data 64'h1234 -> mmio_wr_en one cycle at T+1 with addr 16'h0050, data 64'h1234; no response; err_count=0.
- 4-byte read addr 16'h0052, tid 9'h1A5, RD_LATENCY=2, user returns 64'hAAAA_BBBB_CCCC_DDDD -> rd_en at T+1; rsp_valid at T+4 with data 64'h0000_0000_CCCC_DDDD and tid 9'h1A5.
- 8-byte read then 8-byte write at addr 16'h0053 -> read response data all-ones with its tid, no rd_en/wr_en for either, err_count=2.
- 10 back-to-back reads, tids 0..9, rsp_ready=0, RSP_DEPTH=8 -> req_ready drops after 8 accepts. Set rsp_ready=1 -> tids 0..9 return in order, no loss or duplication.
- Assert rst while 3 reads are in flight and 2 responses are buffered -> rsp_valid=0 immediately, err_count=0, req_ready=1; no stale responses after release.
- Force 65540 misaligned writes -> err_count holds at 16'hFFFF.

Source files
------------

// File: rtl/mmio_host_bridge_if.sv
// Bus bundle between the MMIO host bridge, the HAL shim (requests/responses)
// and the user register map (wr/rd strobes). "master" is the bridge's view.
interface mmio_host_bridge_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int TID_WIDTH  = 9
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic                  req_len8;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [63:0]           req_data;
    logic [TID_WIDTH-1:0]  req_tid;

    logic                  mmio_wr_en;
    logic [ADDR_WIDTH-1:0] mmio_wr_addr;
    logic [63:0]           mmio_wr_data;
    logic                  mmio_rd_en;
    logic [ADDR_WIDTH-1:0] mmio_rd_addr;
    logic [63:0]           mmio_rd_data;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [63:0]           rsp_data;
    logic [TID_WIDTH-1:0]  rsp_tid;

    modport master (
        input  req_valid, req_write, req_len8, req_addr, req_data, req_tid,
        output req_ready,
        output mmio_wr_en, mmio_wr_addr, mmio_wr_data, mmio_rd_en, mmio_rd_addr,
        input  mmio_rd_data,
        output rsp_valid, rsp_data, rsp_tid,
        input  rsp_ready
    );

    modport slave (
        output req_valid, req_write, req_len8, req_addr, req_data, req_tid,
        input  req_ready,
        input  mmio_wr_en, mmio_wr_addr, mmio_wr_data, mmio_rd_en, mmio_rd_addr,
        output mmio_rd_data,
        input  rsp_valid, rsp_data, rsp_tid,
        output rsp_ready
    );
endinterface

// File: rtl/mmio_host_bridge.sv
// MMIO host bridge: turns HAL requests into one-cycle wr/rd strobes, captures
// read data after RD_LATENCY cycles and returns in-order tagged responses
// through a first-word-fall-through FIFO. Misaligned 8-byte accesses are
// counted and answered with all-ones data so response order is preserved.
module mmio_host_bridge #(
    parameter int ADDR_WIDTH = 16,
    parameter int TID_WIDTH  = 9,
    parameter int RD_LATENCY = 0,
    parameter int RSP_DEPTH  = 8
) (
    input  logic               clk,
    input  logic               rst,
    mmio_host_bridge_if.master bus,
    output logic [15:0]        err_count
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(RSP_DEPTH);

    typedef struct packed {
        logic [TID_WIDTH-1:0] tid;
        logic [63:0]          data;
    } rsp_t;

    logic                  accept, misaligned, wr_ok, rd_ok, rd_any;
    logic [CW:0]           occupancy;
    logic                  wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [63:0]           wr_data_q, wr_data_d;
    logic [RD_LATENCY:0]   vld_pipe_q, vld_pipe_d;
    logic [RD_LATENCY:0]   len8_pipe_q, len8_pipe_d;
    logic [RD_LATENCY:0]   mis_pipe_q, mis_pipe_d;
    logic [RD_LATENCY:0][TID_WIDTH-1:0] tid_pipe_q, tid_pipe_d;
    logic [CW-1:0]         inflight_q, inflight_d, fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    rsp_t                  mem_q [RSP_DEPTH];
    rsp_t                  mem_d [RSP_DEPTH];
    rsp_t                  push_entry;
    logic                  push, pop;
    logic [15:0]           err_q, err_d;

    // Admission: reserve a FIFO slot for every read in flight so the FIFO can never overflow.
    always_comb begin
        occupancy     = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
        bus.req_ready = occupancy < DEPTH_W;
        accept        = bus.req_valid && bus.req_ready;
        misaligned    = bus.req_len8 && bus.req_addr[0];
        wr_ok         = accept && bus.req_write && !misaligned;
        rd_ok         = accept && !bus.req_write && !misaligned;
        rd_any        = accept && !bus.req_write;
    end

    // Strobe stage: one-cycle wr/rd enables in the cycle after acceptance.
    always_comb begin
        wr_en_d   = wr_ok;
        rd_en_d   = rd_ok;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_addr_d = rd_addr_q;
        if (wr_ok) begin
            wr_addr_d = bus.req_addr;
            wr_data_d = bus.req_len8 ? bus.req_data : {32'h0, bus.req_data[31:0]};
        end
        if (rd_ok) rd_addr_d = bus.req_addr;
    end

    // Read tag pipeline: stage 0 lines up with rd_en, the last stage with valid user data.
    always_comb begin
        vld_pipe_d     = vld_pipe_q;
        len8_pipe_d    = len8_pipe_q;
        mis_pipe_d     = mis_pipe_q;
        tid_pipe_d     = tid_pipe_q;
        vld_pipe_d[0]  = rd_any;
        len8_pipe_d[0] = bus.req_len8;
        mis_pipe_d[0]  = misaligned;
        tid_pipe_d[0]  = bus.req_tid;
        for (int i = 1; i <= RD_LATENCY; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            len8_pipe_d[i] = len8_pipe_q[i-1];
            mis_pipe_d[i]  = mis_pipe_q[i-1];
            tid_pipe_d[i]  = tid_pipe_q[i-1];
        end
    end

    // Response capture, FIFO bookkeeping, in-flight tracking and error counter.
    always_comb begin
        push            = vld_pipe_q[RD_LATENCY];
        pop             = (fifo_cnt_q != '0) && bus.rsp_ready;
        push_entry.tid  = tid_pipe_q[RD_LATENCY];
        if (mis_pipe_q[RD_LATENCY])       push_entry.data = 64'hFFFF_FFFF_FFFF_FFFF;
        else if (len8_pipe_q[RD_LATENCY]) push_entry.data = bus.mmio_rd_data;
        else                              push_entry.data = {32'h0, bus.mmio_rd_data[31:0]};

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop)      fifo_cnt_d = fifo_cnt_q + CW'(1);
        else if (!push && pop) fifo_cnt_d = fifo_cnt_q - CW'(1);

        inflight_d = inflight_q;
        if (rd_any && !push)      inflight_d = inflight_q + CW'(1);
        else if (!rd_any && push) inflight_d = inflight_q - CW'(1);

        err_d = err_q;
        if (accept && misaligned && err_q != 16'hFFFF) err_d = err_q + 16'd1;
    end

    // Output drive from registered state; FIFO head falls through.
    always_comb begin
        bus.mmio_wr_en   = wr_en_q;
        bus.mmio_wr_addr = wr_addr_q;
        bus.mmio_wr_data = wr_data_q;
        bus.mmio_rd_en   = rd_en_q;
        bus.mmio_rd_addr = rd_addr_q;
        bus.rsp_valid    = fifo_cnt_q != '0;
        bus.rsp_data     = mem_q[rd_ptr_q].data;
        bus.rsp_tid      = mem_q[rd_ptr_q].tid;
        err_count        = err_q;
    end

    // State registers; reset drops every pending strobe, read and buffered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_addr_q   <= '0;
            vld_pipe_q  <= '0;
            len8_pipe_q <= '0;
            mis_pipe_q  <= '0;
            tid_pipe_q  <= '0;
            inflight_q  <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_q       <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_addr_q   <= rd_addr_d;
            vld_pipe_q  <= vld_pipe_d;
            len8_pipe_q <= len8_pipe_d;
            mis_pipe_q  <= mis_pipe_d;
            tid_pipe_q  <= tid_pipe_d;
            inflight_q  <= inflight_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            err_q       <= err_d;
            mem_q       <= mem_d;
        end
    end
endmodule
